// File: rtl/bp_pkg.sv
// Shared types for the branch predictor update path: 2-bit counter codes,
// update FSM states and the saturating counter update rule.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_cnt_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RES_RD = 2'b01,
        RES_WR = 2'b10
    } upd_st_t;

    // Move one step toward the actual outcome, saturating at both ends.
    function automatic bp_cnt_t sat_update(bp_cnt_t cnt, logic taken);
        bp_cnt_t r;
        r = cnt;
        case (cnt)
            SNT:     r = taken ? WNT : SNT;
            WNT:     r = taken ? WT  : SNT;
            WT:      r = taken ? ST  : WNT;
            ST:      r = taken ? ST  : WT;
            default: r = SNT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pht_update_ctrl_if.sv
// Handshake and PHT bus between fetch/execute, the update controller and the PHT.
// master = controller side, slave = environment (fetch, execute, PHT storage).
interface pht_update_ctrl_if #(
    parameter int PATTERN_WIDTH = 4,
    parameter int QUEUE_DEPTH   = 4
);
    localparam int OCC_W = $clog2(QUEUE_DEPTH + 1);

    logic                     pred_req;
    logic                     pred_ready;
    logic                     pred_valid;
    logic                     pred_taken;
    logic                     res_valid;
    logic                     res_taken;
    logic                     res_ready;
    logic                     mispredict;
    logic [PATTERN_WIDTH-1:0] pattern;
    logic [1:0]               state;
    logic [1:0]               new_state;
    logic                     result_strob;
    logic [PATTERN_WIDTH-1:0] ghr;
    logic [OCC_W-1:0]         outstanding;

    modport master (
        input  pred_req, res_valid, res_taken, state,
        output pred_ready, pred_valid, pred_taken, res_ready, mispredict,
               pattern, new_state, result_strob, ghr, outstanding
    );

    modport slave (
        output pred_req, res_valid, res_taken, state,
        input  pred_ready, pred_valid, pred_taken, res_ready, mispredict,
               pattern, new_state, result_strob, ghr, outstanding
    );

endinterface

// File: rtl/pht_update_ctrl_pend_fifo.sv
// Queue of outstanding predictions: each entry holds {pattern, predicted bit}.
// Oldest entry is always visible on head.
module pht_pend_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign head    = mem[rd_ptr];

    // Entry storage; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/pht_update_ctrl.sv
// PHT read/write master: predicts from the entry at the current GHR, queues
// the pattern used, and on resolution read-modify-writes that same entry.
// GHR only advances when a resolution is written back (non-speculative).
module pht_update_ctrl
    import bp_pkg::*;
#(
    parameter int PATTERN_WIDTH = 4,
    parameter int QUEUE_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst,
    pht_update_ctrl_if.master   bus
);
    localparam int FW    = PATTERN_WIDTH + 1;
    localparam int OCC_W = $clog2(QUEUE_DEPTH + 1);

    upd_st_t                  st_q;
    upd_st_t                  st_d;
    logic [PATTERN_WIDTH-1:0] ghr_q;
    bp_cnt_t                  cnt_q;
    logic                     taken_q;
    logic                     pred_valid_q;
    logic                     pred_taken_q;
    logic                     mispredict_q;

    logic [FW-1:0]            head;
    logic [FW-1:0]            push_data;
    logic                     push;
    logic                     pop;
    logic                     full;
    logic                     empty;
    logic [OCC_W-1:0]         count;
    logic [PATTERN_WIDTH-1:0] head_pattern;
    logic                     head_pred;

    logic                     res_acc;
    logic                     pred_acc;
    logic                     pred_ready;
    logic                     res_ready;
    logic [PATTERN_WIDTH-1:0] pattern;
    bp_cnt_t                  new_state;
    logic                     result_strob;

    assign head_pattern = head[FW-1:1];
    assign head_pred    = head[0];
    assign push_data    = {ghr_q, bus.state[1]};

    pht_pend_fifo #(
        .WIDTH (FW),
        .DEPTH (QUEUE_DEPTH)
    ) u_pend_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Update FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q <= IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    // Next state, handshakes and PHT port mux. A pending resolution blocks
    // new predictions so the queue head cannot change under it.
    always_comb begin
        st_d         = st_q;
        pattern      = ghr_q;
        pred_ready   = 1'b0;
        res_ready    = 1'b0;
        new_state    = SNT;
        result_strob = 1'b0;
        res_acc      = 1'b0;
        pred_acc     = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        case (st_q)
            IDLE: begin
                res_ready  = !empty;
                pred_ready = !full && !(bus.res_valid && !empty);
                res_acc    = bus.res_valid && !empty;
                pred_acc   = bus.pred_req && pred_ready;
                push       = pred_acc;
                if (res_acc) begin
                    st_d = RES_RD;
                end
            end
            RES_RD: begin
                pattern = head_pattern;
                st_d    = RES_WR;
            end
            RES_WR: begin
                pattern      = head_pattern;
                new_state    = sat_update(cnt_q, taken_q);
                result_strob = 1'b1;
                pop          = 1'b1;
                st_d         = IDLE;
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

    // Registered outputs, resolution scratch registers and global history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q        <= '0;
            cnt_q        <= SNT;
            taken_q      <= 1'b0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            pred_valid_q <= pred_acc;
            pred_taken_q <= pred_acc & bus.state[1];
            mispredict_q <= pop && (taken_q != head_pred);
            if (res_acc) begin
                taken_q <= bus.res_taken;
            end
            if (st_q == RES_RD) begin
                cnt_q <= bp_cnt_t'(bus.state);
            end
            if (pop) begin
                ghr_q <= {ghr_q[PATTERN_WIDTH-2:0], taken_q};
            end
        end
    end

    assign bus.pred_ready   = pred_ready;
    assign bus.pred_valid   = pred_valid_q;
    assign bus.pred_taken   = pred_taken_q;
    assign bus.res_ready    = res_ready;
    assign bus.mispredict   = mispredict_q;
    assign bus.pattern      = pattern;
    assign bus.new_state    = new_state;
    assign bus.result_strob = result_strob;
    assign bus.ghr          = ghr_q;
    assign bus.outstanding  = count;

endmodule

// File: tb/tb_pht_update_ctrl.sv
// Bench for pht_update_ctrl: a 16-entry PHT memory on the bus, a reference
// model (counter array, history integer, queue of outstanding branches),
// directed scenarios followed by a randomized predict/resolve mix.
module tb_pht_update_ctrl;
    localparam int W = 4;
    localparam int D = 4;

    typedef struct {
        int pat;
        int pred;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [1:0] pht_mem [16] = '{default: 2'b00};

    int   exp_pht [16];
    int   m_ghr;
    ent_t q [$];

    pht_update_ctrl_if #(.PATTERN_WIDTH(W), .QUEUE_DEPTH(D)) bus ();

    pht_update_ctrl #(.PATTERN_WIDTH(W), .QUEUE_DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // PHT storage: combinational read, written on the strobe.
    assign bus.state = pht_mem[bus.pattern];
    always @(posedge clk) begin
        if (bus.result_strob) pht_mem[bus.pattern] <= bus.new_state;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_next(input int s, input bit taken);
        if (taken) return (s >= 3) ? 3 : s + 1;
        return (s <= 0) ? 0 : s - 1;
    endfunction

    task automatic predict();
        int n;
        int exp_pred;
        n = 0;
        @(negedge clk);
        bus.pred_req = 1'b1;
        #1;
        while (!bus.pred_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("pred_ready", bus.pred_ready, 1);
        check("pred_pattern", bus.pattern, m_ghr);
        exp_pred = (exp_pht[m_ghr] >= 2) ? 1 : 0;
        q.push_back('{m_ghr, exp_pred});
        @(negedge clk);
        bus.pred_req = 1'b0;
        #1;
        check("pred_valid", bus.pred_valid, 1);
        check("pred_taken", bus.pred_taken, exp_pred);
        check("pred_outstanding", bus.outstanding, q.size());
    endtask

    // Model-side write-back of the oldest branch; returns the expected new counter.
    task automatic model_resolve(input bit taken, output ent_t e, output int ns);
        e  = q.pop_front();
        ns = sat_next(exp_pht[e.pat], taken);
        exp_pht[e.pat] = ns;
        m_ghr = ((m_ghr << 1) | int'(taken)) & ((1 << W) - 1);
    endtask

    task automatic resolve(input bit taken);
        ent_t e;
        int   ns;
        @(negedge clk);
        bus.res_valid = 1'b1;
        bus.res_taken = taken;
        #1;
        check("res_ready", bus.res_ready, 1);
        @(negedge clk);
        bus.res_valid = 1'b0;
        bus.res_taken = 1'b0;
        #1;
        check("rd_handshakes", {bus.pred_ready, bus.res_ready}, 0);
        check("rd_strob", bus.result_strob, 0);
        model_resolve(taken, e, ns);
        @(negedge clk);
        #1;
        check("wr_strob", bus.result_strob, 1);
        check("wr_pattern", bus.pattern, e.pat);
        check("wr_new_state", bus.new_state, ns);
        @(negedge clk);
        #1;
        check("mispredict", bus.mispredict, (int'(taken) != e.pred) ? 1 : 0);
        check("ghr", bus.ghr, m_ghr);
        check("res_outstanding", bus.outstanding, q.size());
        check("pht_written", pht_mem[e.pat], ns);
        check("strob_off", {bus.result_strob, bus.new_state}, 0);
    endtask

    initial begin
        ent_t e;
        int   ns;
        int   exp_pred;
        int   pat_save;

        for (int i = 0; i < 16; i++) exp_pht[i] = 0;
        m_ghr = 0;
        bus.pred_req  = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_taken = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check("rst_outputs", {bus.pred_valid, bus.pred_taken, bus.mispredict,
                              bus.result_strob, bus.new_state}, 0);
        check("rst_ghr", bus.ghr, 0);
        check("rst_outstanding", bus.outstanding, 0);
        check("rst_res_ready", bus.res_ready, 0);
        rst = 1'b0;

        // First prediction, then three taken resolutions walking the history
        predict();
        resolve(1'b1);
        predict();
        resolve(1'b1);
        predict();
        resolve(1'b1);

        // Drive history back to zero, then saturate entry 0 upward
        repeat (5) begin
            predict();
            resolve(1'b0);
        end
        check("ghr_zero", bus.ghr, 0);
        repeat (4) predict();
        check("full_outstanding", bus.outstanding, 4);
        check("full_pred_ready", bus.pred_ready, 0);
        resolve(1'b1);
        check("after_pop_pred_ready", bus.pred_ready, 1);
        repeat (3) resolve(1'b1);
        check("entry0_saturated", pht_mem[0], 3);

        // Simultaneous request and resolution: resolution wins, prediction waits
        predict();
        @(negedge clk);
        bus.pred_req  = 1'b1;
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b0;
        #1;
        check("sim_pred_ready", bus.pred_ready, 0);
        check("sim_res_ready", bus.res_ready, 1);
        @(negedge clk);
        bus.res_valid = 1'b0;
        #1;
        check("sim_rd_pred_ready", bus.pred_ready, 0);
        model_resolve(1'b0, e, ns);
        @(negedge clk);
        #1;
        check("sim_wr_pred_ready", bus.pred_ready, 0);
        check("sim_wr_new_state", bus.new_state, ns);
        @(negedge clk);
        #1;
        check("sim_idle_pred_ready", bus.pred_ready, 1);
        check("sim_idle_pattern", bus.pattern, m_ghr);
        check("sim_mispredict", bus.mispredict, (e.pred != 0) ? 1 : 0);
        exp_pred = (exp_pht[m_ghr] >= 2) ? 1 : 0;
        q.push_back('{m_ghr, exp_pred});
        @(negedge clk);
        bus.pred_req = 1'b0;
        #1;
        check("sim_pred_valid", bus.pred_valid, 1);
        check("sim_pred_taken", bus.pred_taken, exp_pred);
        while (q.size() > 0) resolve(1'b0);

        // Resolution with empty queue is ignored
        @(negedge clk);
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b1;
        #1;
        check("empty_res_ready", bus.res_ready, 0);
        @(negedge clk);
        #1;
        check("empty_strob", bus.result_strob, 0);
        @(negedge clk);
        bus.res_valid = 1'b0;
        bus.res_taken = 1'b0;
        #1;
        check("empty_strob2", bus.result_strob, 0);
        check("empty_ghr", bus.ghr, m_ghr);
        check("empty_outstanding", bus.outstanding, 0);

        // Randomized mix against the model
        repeat (80) begin
            if (q.size() > 0 && (q.size() == D || $urandom_range(1, 0) == 1))
                resolve(1'($urandom_range(1, 0)));
            else
                predict();
        end

        // Reset in the middle of a write-back aborts it
        if (q.size() == 0) predict();
        pat_save = q[0].pat;
        @(negedge clk);
        bus.res_valid = 1'b1;
        bus.res_taken = (exp_pht[pat_save] >= 2) ? 1'b0 : 1'b1;
        @(negedge clk);
        bus.res_valid = 1'b0;
        @(negedge clk);
        #1;
        check("abort_in_wr", bus.result_strob, 1);
        rst = 1'b1;
        #1;
        check("abort_strob", bus.result_strob, 0);
        check("abort_new_state", bus.new_state, 0);
        check("abort_ghr", bus.ghr, 0);
        check("abort_outstanding", bus.outstanding, 0);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_ghr = 0;
        #1;
        check("abort_no_write", pht_mem[pat_save], exp_pht[pat_save]);
        predict();
        resolve(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
